dm_resp: RTL and testbench
==========================

Name: dm_resp

Overview:
- Data-memory responder for the SISC datapath; the target end of the memory request that the control FSM raises during its mem state for LOD/STR.
- Accepts a 4-phase req/ack handshake, inserts a programmable number of wait states, performs a word read or write on an internal single-port array, and returns read data or an out-of-range error.

Parameters:
- ADDR_W, 16, address width in words
- DATA_W, 32, data word width
- DEPTH, 256, number of implemented words; valid addresses are 0..DEPTH-1
- WAIT_CYC, 2, wait states inserted before the access (0..15)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_f  in  1  reset, synchronous, active-low
- req  in  1  request from initiator; level, 4-phase
- we  in  1  1 = store (STR), 0 = load (LOD); sampled with req
- addr  in  ADDR_W  word address; sampled with req
- wdata  in  DATA_W  store data; sampled with req
- rdata  out  DATA_W  load data; valid while ack=1
- ack  out  1  access complete; held until req drops
- err  out  1  address >= DEPTH; valid while ack=1
- busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset is synchronous, active-low. It applies at any posedge where rst_f=0, including mid-transaction, and forces:
  - state=IDLE
  - rdata=0, ack=0, err=0, busy=0
  - wait counter cleared
- Reset does not clear array contents, and no write is performed in the cycle reset is applied.
- All outputs are registered.
- States:
  - IDLE: if req=1, latch addr, we and wdata into holding registers, load cnt=WAIT_CYC, and go to WAIT. Otherwise stay.
  - WAIT: if cnt≠0, decrement cnt and stay. If cnt=0, perform the access, set ack=1, and go to HOLD.
  - HOLD: keep ack, rdata and err stable. When req=0 is sampled, clear ack, err and rdata to 0 and go to IDLE.
- Latency: if req is first sampled at edge E0, ack rises at edge E0+WAIT_CYC+1. With WAIT_CYC=0, ack rises at E0+1.
- Access at the WAIT→HOLD edge, using the latched values only:
  - Latched address < DEPTH, we=1: array[addr] <= wdata; rdata=0; err=0.
  - Latched address < DEPTH, we=0: rdata <= array[addr]; err=0.
  - Latched address >= DEPTH: no array write; rdata=0; err=1. ack still asserts.
- Changes on addr, we or wdata after the latch edge are ignored until the next IDLE.
- req falling during WAIT is a protocol violation. The access still commits, ack pulses for exactly one cycle (HOLD sees req=0 on the next edge), then the FSM returns to IDLE.
- Back-to-back requests: req must be sampled low in HOLD before a new request is accepted. Minimum spacing is WAIT_CYC+3 edges per transaction.
- Read-after-write to the same address returns the newly written value.
- Address arithmetic:
  - Only addr[$clog2(DEPTH)-1:0] indexes the array.
  - The upper bits are used only for the range check, which compares the full ADDR_W-bit address. Addresses never wrap.

Decomposition:
- sisc_mem_pkg:
  - state encoding (IDLE=0, WAIT=1, HOLD=2)
  - default ADDR_W/DATA_W/DEPTH/WAIT_CYC constants
  - LOD/STR opcode values (1, 2), shared with the control FSM
- Sub-module dm_array: synchronous single-port RAM, DEPTH x DATA_W.
  - Ports: clk, en, we, a, d, q.
  - Registered read.
  - No reset.
  - dm_resp drives en only in the access cycle.

Test Plan:
- Write then read (WAIT_CYC=2): store addr=0x0010, wdata=0xDEADBEEF; ack rises 3 edges after the req sample, err=0. Release req, then load 0x0010: rdata=0xDEADBEEF with ack, err=0.
- Zero wait (WAIT_CYC=0): load from 0x0000 after storing 0x00000005 there. ack rises 1 edge after the req sample, rdata=0x00000005, busy high for exactly 2 cycles including HOLD.
- Out of range (DEPTH=256): store addr=0x0100, wdata=0x12345678 → ack=1, err=1, rdata=0. A subsequent load of 0x0000 returns its prior value, confirming no aliasing.
- Input change after latch: req at addr=0x0003; change addr to 0x0004 and wdata to 0xFFFFFFFF on the next cycle. The original wdata lands at 0x0003 and 0x0004 is unchanged.
- Early req drop: req high for 1 cycle only during a store → ack pulses 1 cycle, the write to the target address is committed, and the FSM is back in IDLE (busy=0) the following edge.
- Reset mid-op: assert rst_f=0 in WAIT → next edge ack=0, busy=0, rdata=0, and the write did not occur. Previously written locations retain their data after rst_f=1.

Source files
------------

// File: rtl/sisc_mem_pkg.sv
// Shared definitions for the SISC data-memory path.
// Holds the responder state encoding, the default geometry and timing
// constants, and the LOD/STR opcode values that the control FSM also uses.
package sisc_mem_pkg;

  localparam int unsigned DM_ADDR_W   = 16;
  localparam int unsigned DM_DATA_W   = 32;
  localparam int unsigned DM_DEPTH    = 256;
  localparam int unsigned DM_WAIT_CYC = 2;
  // Wait counter width; covers WAIT_CYC of 0..15.
  localparam int unsigned DM_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } dm_state_e;

  typedef enum logic [1:0] {
    OP_LOD = 2'd1,
    OP_STR = 2'd2
  } sisc_mem_op_e;

endpackage : sisc_mem_pkg

// File: rtl/dm_resp_if.sv
// Memory request bus between the SISC control FSM (master) and the
// data-memory responder (slave).
//   req   : 4-phase request level          (master -> slave)
//   we    : 1 = store, 0 = load            (master -> slave)
//   addr  : word address                   (master -> slave)
//   wdata : store data                     (master -> slave)
//   rdata : load data, valid with ack      (slave -> master)
//   ack   : access complete, held until req drops (slave -> master)
//   err   : address out of range, valid with ack  (slave -> master)
//   busy  : responder not idle             (slave -> master)
interface dm_resp_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );

endinterface : dm_resp_if

// File: rtl/dm_array.sv
// Synchronous single-port RAM, DEPTH x DATA_W, registered read, no reset.
//   clk : clock
//   en  : access enable; nothing happens when low
//   we  : 1 = write d to a, 0 = read a into q
//   a   : word index
//   d   : write data
//   q   : read data, updated on the edge after a read access
module dm_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  a,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // q keeps its last read value across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[a] <= d;
      end else begin
        q <= mem[a];
      end
    end
  end

endmodule : dm_array

// File: rtl/dm_resp.sv
// Data-memory responder: target of the SISC LOD/STR memory request.
// Accepts a 4-phase req/ack handshake, waits WAIT_CYC cycles, then does one
// word access on the internal array and returns read data or a range error.
//   clk   : clock, all logic on posedge
//   rst_f : synchronous active-low reset
//   bus   : dm_resp_if slave modport (req/we/addr/wdata in,
//           rdata/ack/err/busy out)
module dm_resp
  import sisc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DM_ADDR_W,
  parameter int unsigned DATA_W   = DM_DATA_W,
  parameter int unsigned DEPTH    = DM_DEPTH,
  parameter int unsigned WAIT_CYC = DM_WAIT_CYC
) (
  input  logic      clk,
  input  logic      rst_f,
  dm_resp_if.slave  bus
);

  localparam int unsigned  IDX_W     = $clog2(DEPTH);
  localparam int unsigned  CNT_W     = DM_CNT_W;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q,   ack_d;
  logic              err_q,   err_d;
  logic              busy_q,  busy_d;
  logic              rd_vld_q, rd_vld_d;

  logic              in_range_c;
  logic              access_c;
  logic              ram_en_c;
  logic [DATA_W-1:0] ram_q;

  // Range check uses the full latched address; only the low bits index the array.
  assign in_range_c = ({1'b0, addr_q} < DEPTH_EXT);
  assign access_c   = (state_q == ST_WAIT) && (cnt_q == '0);
  // Gated by rst_f so a reset landing on the access edge suppresses the write.
  assign ram_en_c   = access_c && in_range_c && rst_f;

  dm_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_dm_array (
    .clk (clk),
    .en  (ram_en_c),
    .we  (we_q),
    .a   (addr_q[IDX_W-1:0]),
    .d   (wdata_q),
    .q   (ram_q)
  );

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = ack_q;
    err_d    = err_q;
    rd_vld_d = rd_vld_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CNT_W'(WAIT_CYC);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d  = ST_HOLD;
          ack_d    = 1'b1;
          err_d    = !in_range_c;
          rd_vld_d = in_range_c && !we_q;
        end
      end
      ST_HOLD: begin
        if (!bus.req) begin
          state_d  = ST_IDLE;
          ack_d    = 1'b0;
          err_d    = 1'b0;
          rd_vld_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rd_vld_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // RAM q is itself a register and stays frozen during HOLD; rd_vld_q
  // masks it so rdata reads 0 outside a successful load.
  assign bus.rdata = rd_vld_q ? ram_q : '0;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule : dm_resp

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: instance A with WAIT_CYC=2, instance B with WAIT_CYC=0.
module tb_dm_resp;
  import sisc_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_f;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model   [2][256];
  logic        written [2][256];

  dm_resp_if #(.ADDR_W(16), .DATA_W(32)) bus_a ();
  dm_resp_if #(.ADDR_W(16), .DATA_W(32)) bus_b ();

  dm_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYC(2)) u_dut_a (
    .clk(clk), .rst_f(rst_f), .bus(bus_a)
  );
  dm_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYC(0)) u_dut_b (
    .clk(clk), .rst_f(rst_f), .bus(bus_b)
  );

  function automatic logic ack_of(int i);
    return (i == 0) ? bus_a.ack : bus_b.ack;
  endfunction
  function automatic logic err_of(int i);
    return (i == 0) ? bus_a.err : bus_b.err;
  endfunction
  function automatic logic busy_of(int i);
    return (i == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  function automatic logic [31:0] rdata_of(int i);
    return (i == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  task automatic drive(input int i, input logic r, input logic w,
                       input logic [15:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
    end else begin
      bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
    end
  endtask

  // Full handshake on instance i; expectation comes from the bench model.
  task automatic txn(input int i, input logic w, input logic [15:0] a,
                     input logic [31:0] d, input int wc, input string nm);
    exp_t e;
    exp_t got;
    int   n;
    int   bcnt;
    if (a >= 16'd256) begin
      e = '{rdata: 32'h0, err: 1'b1};
    end else if (w) begin
      e = '{rdata: 32'h0, err: 1'b0};
      model[i][a[7:0]]   = d;
      written[i][a[7:0]] = 1'b1;
    end else begin
      e = '{rdata: model[i][a[7:0]], err: 1'b0};
    end
    sb_q.push_back(e);
    @(negedge clk);
    drive(i, 1'b1, w, a, d);
    @(posedge clk); #1;
    bcnt = busy_of(i) ? 1 : 0;
    n = 0;
    while (!ack_of(i) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy_of(i)) bcnt++;
    end
    checks++;
    if (!ack_of(i)) begin
      errors++;
      $display("FAIL %s ack_timeout: got ack=%0b want 1", nm, ack_of(i));
    end
    checks++;
    if (n !== wc + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, n, wc + 1);
    end
    got = sb_q.pop_front();
    checks++;
    if (rdata_of(i) !== got.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %08h want %08h", nm, rdata_of(i), got.rdata);
    end
    checks++;
    if (err_of(i) !== got.err) begin
      errors++;
      $display("FAIL %s err: got %0b want %0b", nm, err_of(i), got.err);
    end
    @(negedge clk);
    drive(i, 1'b0, w, a, d);
    @(posedge clk); #1;
    checks++;
    if (ack_of(i) !== 1'b0 || busy_of(i) !== 1'b0 || rdata_of(i) !== 32'h0) begin
      errors++;
      $display("FAIL %s release: got ack=%0b busy=%0b rdata=%08h want 0 0 0",
               nm, ack_of(i), busy_of(i), rdata_of(i));
    end
    checks++;
    if (bcnt !== wc + 2) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, bcnt, wc + 2);
    end
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ack_of(i) !== 1'b0 || err_of(i) !== 1'b0 || busy_of(i) !== 1'b0 ||
          rdata_of(i) !== 32'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got ack=%0b err=%0b busy=%0b rdata=%08h want 0",
                 i, ack_of(i), err_of(i), busy_of(i), rdata_of(i));
      end
    end
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, 2, "wr_0010");
    txn(0, 1'b0, 16'h0010, 32'h0,        2, "rd_0010");
  endtask

  task automatic test_zero_wait();
    txn(1, 1'b1, 16'h0000, 32'h00000005, 0, "zw_wr_0000");
    txn(1, 1'b0, 16'h0000, 32'h0,        0, "zw_rd_0000");
  endtask

  task automatic test_out_of_range();
    txn(0, 1'b1, 16'h0000, 32'hA5A50000, 2, "oor_seed_0000");
    txn(0, 1'b1, 16'h0100, 32'h12345678, 2, "oor_wr_0100");
    txn(0, 1'b0, 16'h0000, 32'h0,        2, "oor_rd_0000");
    txn(0, 1'b0, 16'hFFFF, 32'h0,        2, "oor_rd_ffff");
  endtask

  task automatic test_latch_change();
    int   n;
    exp_t got;
    txn(0, 1'b1, 16'h0004, 32'h44440004, 2, "lc_seed_0004");
    model[0][3]   = 32'h33330003;
    written[0][3] = 1'b1;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0003, 32'h33330003);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0004, 32'hFFFFFFFF);
    n = 1;
    @(posedge clk); #1;
    while (!ack_of(0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    got = sb_q.pop_front();
    checks++;
    if (n !== 3 || err_of(0) !== got.err) begin
      errors++;
      $display("FAIL latch_change_ack: got lat=%0d err=%0b want 3 %0b", n, err_of(0), got.err);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0004, 32'hFFFFFFFF);
    @(posedge clk);
    txn(0, 1'b0, 16'h0003, 32'h0, 2, "lc_rd_0003");
    txn(0, 1'b0, 16'h0004, 32'h0, 2, "lc_rd_0004");
  endtask

  task automatic test_early_drop();
    logic exp_ack [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    model[0][8'h20]   = 32'hCAFE0020;
    written[0][8'h20] = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0020, 32'hCAFE0020);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0020, 32'hCAFE0020);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ack_of(0) !== exp_ack[k]) begin
        errors++;
        $display("FAIL early_drop_ack[E0+%0d]: got %0b want %0b", k + 1, ack_of(0), exp_ack[k]);
      end
    end
    checks++;
    if (busy_of(0) !== 1'b0) begin
      errors++;
      $display("FAIL early_drop_busy: got %0b want 0", busy_of(0));
    end
    txn(0, 1'b0, 16'h0020, 32'h0, 2, "ed_rd_0020");
  endtask

  task automatic test_reset_mid();
    txn(0, 1'b1, 16'h0030, 32'h11110030, 2, "rm_seed_0030");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0030, 32'h22220030);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    // Reset sampled on the edge where the write would commit.
    @(negedge clk);
    rst_f = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0030, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (ack_of(0) !== 1'b0 || busy_of(0) !== 1'b0 || rdata_of(0) !== 32'h0 ||
        err_of(0) !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got ack=%0b busy=%0b err=%0b rdata=%08h want 0",
               ack_of(0), busy_of(0), err_of(0), rdata_of(0));
    end
    @(negedge clk);
    rst_f = 1'b1;
    txn(0, 1'b0, 16'h0030, 32'h0, 2, "rm_rd_0030");
    txn(0, 1'b0, 16'h0010, 32'h0, 2, "rm_rd_0010");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic        w;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom_range(0, 287));
      w = 1'($urandom_range(0, 1));
      if (a < 16'd256 && !written[0][a[7:0]]) w = 1'b1;
      txn(0, w, a, $urandom, 2, "b2b");
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) begin
        model[i][j]   = 32'h0;
        written[i][j] = 1'b0;
      end
    test_reset();
    test_write_read();
    test_zero_wait();
    test_out_of_range();
    test_latch_change();
    test_early_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dm_resp
